// File: rtl/side_ch_csi_packer_if.sv
// Write port of the side-channel master-stream FIFO.
// The packer drives the word and its strobe; the FIFO returns space-available.
interface side_ch_csi_packer_if #(
    parameter int DW = 64
) ();
    logic [DW-1:0] data_to_ps;
    logic          data_to_ps_valid;
    logic          fulln_to_pl;

    modport master (output data_to_ps, output data_to_ps_valid, input fulln_to_pl);
    modport slave  (input data_to_ps, input data_to_ps_valid, output fulln_to_pl);
endinterface

// File: rtl/side_ch_csi_packer.sv
// Packs one packet's CSI, RX timestamp and header into a 34-word 64-bit
// record and streams it into the side-channel FIFO write port.
module side_ch_csi_packer #(
    parameter int TSF_TIMER_WIDTH = 64,
    parameter int IQ_DATA_WIDTH   = 16,
    parameter int NUM_CSI         = 64,
    parameter int HDR_TIMEOUT     = 4000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [TSF_TIMER_WIDTH-1:0] tsf_runtime_val,
    input  logic [2*IQ_DATA_WIDTH-1:0] csi,
    input  logic                       csi_valid,
    input  logic                       pkt_header_valid_strobe,
    input  logic [7:0]                 pkt_rate,
    input  logic [15:0]                pkt_len,
    side_ch_csi_packer_if.master       fifo,
    output logic                       busy,
    output logic [15:0]                drop_count
);
    localparam int WW     = 4 * IQ_DATA_WIDTH;
    localparam int NWORDS = NUM_CSI / 2 + 2;
    localparam int CNT_W  = $clog2(NUM_CSI);
    localparam int AW     = $clog2(NUM_CSI / 2);
    localparam int IDX_W  = $clog2(NWORDS);
    localparam int TO_W   = $clog2(HDR_TIMEOUT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [TO_W-1:0]            to_q, to_d;
    logic [TSF_TIMER_WIDTH-1:0] tsf_q, tsf_d;
    logic [7:0]                 rate_q, rate_d;
    logic [15:0]                len_q, len_d;
    logic [2*IQ_DATA_WIDTH-1:0] even_q, even_d;
    logic [WW-1:0]              dout_q, dout_d;
    logic                       dval_q, dval_d;
    logic [15:0]                drop_q, drop_d;
    logic                       csi_vld_prev_q;
    logic [WW-1:0]              buf_q [NUM_CSI/2];

    logic                       buf_we, drop_evt, miss_evt;
    logic [AW-1:0]              wr_addr, rd_addr;
    logic [WW-1:0]              word;
    logic [16:0]                drop_sum;

    assign wr_addr = cnt_q[CNT_W-1:1];
    assign rd_addr = AW'(idx_q - IDX_W'(2));

    always_comb begin
        case (idx_q)
            IDX_W'(0): word = {16'h5A5A, 8'h00, rate_q, len_q, 16'(NWORDS)};
            IDX_W'(1): word = WW'(tsf_q);
            default:   word = buf_q[rd_addr];
        endcase
    end

    // A fresh csi_valid burst while the previous record is still pending is a lost packet.
    assign miss_evt = csi_valid && !csi_vld_prev_q && (state_q == S_WAIT || state_q == S_EMIT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        to_d     = to_q;
        tsf_d    = tsf_q;
        rate_d   = rate_q;
        len_d    = len_q;
        even_d   = even_q;
        dout_d   = dout_q;
        dval_d   = 1'b0;
        buf_we   = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && csi_valid) begin
                    tsf_d   = tsf_runtime_val;
                    even_d  = csi;
                    cnt_d   = CNT_W'(1);
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (pkt_header_valid_strobe) begin
                    drop_evt = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if (csi_valid) begin
                    if (cnt_q[0]) buf_we = 1'b1;
                    else          even_d = csi;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_CSI - 1)) begin
                        to_d    = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                to_d = to_q + TO_W'(1);
                if (pkt_header_valid_strobe) begin
                    rate_d  = pkt_rate;
                    len_d   = pkt_len;
                    idx_d   = '0;
                    state_d = S_EMIT;
                end else if (to_q == TO_W'(HDR_TIMEOUT - 1)) begin
                    drop_evt = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                if (fifo.fulln_to_pl) begin
                    dout_d = word;
                    dval_d = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NWORDS - 1)) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        drop_sum = {1'b0, drop_q} + 17'(drop_evt) + 17'(miss_evt);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            to_q           <= '0;
            tsf_q          <= '0;
            rate_q         <= '0;
            len_q          <= '0;
            even_q         <= '0;
            dout_q         <= '0;
            dval_q         <= 1'b0;
            drop_q         <= '0;
            csi_vld_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            to_q           <= to_d;
            tsf_q          <= tsf_d;
            rate_q         <= rate_d;
            len_q          <= len_d;
            even_q         <= even_d;
            dout_q         <= dout_d;
            dval_q         <= dval_d;
            drop_q         <= drop_d;
            csi_vld_prev_q <= csi_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_addr] <= {csi, even_q};
    end

    assign fifo.data_to_ps       = dout_q;
    assign fifo.data_to_ps_valid = dval_q;
    assign busy                  = (state_q != S_IDLE);
    assign drop_count            = drop_q;
endmodule

// File: tb/tb_side_ch_csi_packer.sv
// Directed bench for side_ch_csi_packer: a table of packet scenarios plus
// hand-written timeout, missed-packet, collision and mid-record reset sequences.
module tb_side_ch_csi_packer;
    localparam int HDR_TIMEOUT = 4000;

    typedef struct {
        int          n_csi;
        bit          send_hdr;
        bit          bp;
        bit          gap;
        logic [63:0] tsf;
        logic [7:0]  rate;
        logic [15:0] len;
        logic [31:0] base;
        int          exp_words;
        int          drop_inc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, enable, csi_valid, hdr;
    logic [63:0] tsf;
    logic [31:0] csi;
    logic [7:0]  rate;
    logic [15:0] len;
    logic        busy;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;
    int cyc = 0;
    logic fulln_prev = 1'b1;
    logic [63:0] q[$];
    int scyc[$];
    vec_t vecs[4];

    side_ch_csi_packer_if #(.DW(64)) pif ();

    side_ch_csi_packer #(.HDR_TIMEOUT(HDR_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tsf_runtime_val(tsf),
        .csi(csi), .csi_valid(csi_valid), .pkt_header_valid_strobe(hdr),
        .pkt_rate(rate), .pkt_len(len), .fifo(pif.master),
        .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Collect strobed words; a strobe right after a cycle with fulln low is a violation.
    always @(negedge clk) begin
        cyc++;
        if (pif.data_to_ps_valid) begin
            q.push_back(pif.data_to_ps);
            scyc.push_back(cyc);
            checks++;
            if (!fulln_prev) begin
                errors++;
                $display("FAIL strobe_after_full: got valid=1 at cycle %0d, required 0", cyc);
            end
        end
        fulln_prev = pif.fulln_to_pl;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required run completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input vec_t v, input int k);
        if (k == 0) return {16'h5A5A, 8'h00, v.rate, v.len, 16'd34};
        if (k == 1) return v.tsf;
        return {v.base + 32'(2 * (k - 2) + 1), v.base + 32'(2 * (k - 2))};
    endfunction

    task automatic send_csi(input int n, input logic [31:0] base, input logic [63:0] t0, input bit gap);
        for (int i = 0; i < n; i++) begin
            tsf = t0 + 64'(i);
            csi = base + 32'(i);
            csi_valid = 1'b1;
            tick();
            csi_valid = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic send_hdr(input logic [7:0] r, input logic [15:0] l);
        rate = r;
        len = l;
        hdr = 1'b1;
        tick();
        hdr = 1'b0;
    endtask

    task automatic check_record(input vec_t v, input string tag);
        chk({tag, "_nwords"}, 64'(q.size()), 64'(v.exp_words));
        for (int k = 0; k < q.size() && k < v.exp_words; k++)
            chk($sformatf("%s_word%0d", tag, k), q[k], exp_word(v, k));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        q.delete();
        scyc.delete();
        send_csi(v.n_csi, v.base, v.tsf, v.gap);
        if (v.send_hdr) send_hdr(v.rate, v.len);
        for (int c = 0; c < 100; c++) begin
            pif.fulln_to_pl = v.bp ? (c % 2 == 0) : 1'b1;
            tick();
        end
        pif.fulln_to_pl = 1'b1;
        exp_drop += v.drop_inc;
        check_record(v, tag);
        chk({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        if (!v.bp && scyc.size() == 34)
            chk({tag, "_consecutive"}, 64'(scyc[33] - scyc[0]), 64'd33);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{64, 1'b1, 1'b0, 1'b0, 64'h1000, 8'h0B, 16'd100, 32'h0, 34, 0};
        vecs[1] = '{64, 1'b1, 1'b1, 1'b0, 64'h2000, 8'h0B, 16'd100, 32'h0, 34, 0};
        vecs[2] = '{10, 1'b1, 1'b0, 1'b0, 64'h3000, 8'h01, 16'd5,   32'h50, 0, 1};
        vecs[3] = '{64, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, 8'hFF, 16'hFFFF, 32'h0001_0100, 34, 0};

        rst = 1'b1; enable = 1'b0; csi_valid = 1'b0; hdr = 1'b0;
        tsf = '0; csi = '0; rate = '0; len = '0; pif.fulln_to_pl = 1'b1;
        repeat (3) tick();
        chk("rst_data", pif.data_to_ps, 64'd0);
        chk("rst_valid", 64'(pif.data_to_ps_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;
        enable = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0 && q.size() == 34) begin
                chk("basic_w0", q[0], 64'h5A5A_000B_0064_0022);
                chk("basic_w1", q[1], 64'h0000_0000_0000_1000);
                chk("basic_w2", q[2], 64'h0000_0001_0000_0000);
                chk("basic_w33", q[33], 64'h0000_003F_0000_003E);
            end
        end

        // csi_valid colliding with the header in COLLECT: header wins, record drops
        send_csi(20, 32'h700, 64'h4000, 1'b0);
        csi = 32'hFFFF_FFFF;
        csi_valid = 1'b1;
        send_hdr(8'h02, 16'd40);
        csi_valid = 1'b0;
        tick();
        exp_drop++;
        chk("collide_busy", 64'(busy), 64'd0);
        chk("collide_drop", 64'(drop_count), 64'(exp_drop));

        // header never arrives: busy holds through the last timeout cycle then drops
        q.delete();
        send_csi(64, 32'h900, 64'h5000, 1'b0);
        repeat (HDR_TIMEOUT - 1) tick();
        chk("timeout_busy_last", 64'(busy), 64'd1);
        chk("timeout_drop_before", 64'(drop_count), 64'(exp_drop));
        tick();
        exp_drop++;
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_drop", 64'(drop_count), 64'(exp_drop));
        repeat (5) tick();
        chk("timeout_nwords", 64'(q.size()), 64'd0);

        // missed packet: a continuous 64-sample burst starts during EMIT
        v = '{64, 1'b1, 1'b0, 1'b0, 64'h6000, 8'h0D, 16'd1500, 32'h200, 34, 1};
        q.delete();
        send_csi(v.n_csi, v.base, v.tsf, 1'b0);
        send_hdr(v.rate, v.len);
        for (int c = 0; c < 20 && q.size() < 2; c++) tick();
        chk("miss_emit_started", 64'(q.size() >= 2), 64'd1);
        enable = 1'b0;
        for (int i = 0; i < 64; i++) begin
            csi = 32'hBAD0_0000 + 32'(i);
            csi_valid = 1'b1;
            tick();
        end
        csi_valid = 1'b0;
        repeat (20) tick();
        enable = 1'b1;
        exp_drop += v.drop_inc;
        check_record(v, "miss");
        chk("miss_drop", 64'(drop_count), 64'(exp_drop));

        // reset in the middle of EMIT
        q.delete();
        send_csi(64, 32'h300, 64'h7000, 1'b0);
        send_hdr(8'h0C, 16'd200);
        for (int c = 0; c < 40 && q.size() < 10; c++) tick();
        chk("rst_mid_reached10", 64'(q.size() >= 10), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", 64'(pif.data_to_ps_valid), 64'd0);
        rst = 1'b0;
        exp_drop = 0;
        chk("rst_mid_drop", 64'(drop_count), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        run_vec(vecs[3], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/side_ch_csi_packer.md
# side_ch_csi_packer

Packs one packet's per-subcarrier CSI, its RX timestamp and its header fields into a fixed 34-word, 64-bit record. Pushes the record into the side-channel master-stream FIFO write port (`data_to_ps` / `data_to_ps_valid` / `fulln_to_pl`). Sits directly upstream of the side-channel m_axis FIFO, between the receiver's equalizer/CSI outputs and the DMA toward the PS.

## Interface
Parameters:
- `TSF_TIMER_WIDTH`, 64, TSF width; must be 64.
- `IQ_DATA_WIDTH`, 16, width of each I and Q part; a CSI sample is 2*IQ_DATA_WIDTH = 32 bits.
- `NUM_CSI`, 64, CSI samples per record; must be even.
- `HDR_TIMEOUT`, 4000, maximum clk cycles to wait for the header after the CSI is complete.

Ports:
- `clk` in 1: single clock for the block.
- `rst` in 1: **synchronous, active-high reset**.
- `enable` in 1: allows a new capture to start; sampled only in IDLE.
- `tsf_runtime_val` in 64: free-running TSF.
- `csi` in 32: {Q, I} CSI sample.
- `csi_valid` in 1: one-cycle qualifier per CSI sample.
- `pkt_header_valid_strobe` in 1: header decoded; `pkt_rate` and `pkt_len` are valid in the same cycle.
- `pkt_rate` in 8: packet rate code.
- `pkt_len` in 16: packet length in bytes.
- `fulln_to_pl` in 1: FIFO can accept a word.
- `data_to_ps` out 64: record word.
- `data_to_ps_valid` out 1: write strobe for `data_to_ps`.
- `busy` out 1: high in any state other than IDLE.
- `drop_count` out 16: count of discarded records; saturates at 16'hFFFF.

## Operation
States:
- **IDLE**
  - Requires `enable`=1.
  - The first `csi_valid` latches `tsf_runtime_val` into tsf_r, stores the sample, sets cnt=1 and moves to COLLECT.
- **COLLECT**
  - Each `csi_valid` stores a sample. Gaps between samples are allowed.
  - Samples are paired: the even sample is held in a register. On the odd sample, {csi_odd, csi_even} is written to buffer entry cnt>>1. The buffer is 32x64 (NUM_CSI/2 entries).
  - When sample NUM_CSI-1 is stored, go to WAIT_HDR and clear the timeout counter.
  - `pkt_header_valid_strobe` arriving in COLLECT means the CSI is incomplete: drop the record, increment `drop_count`, go to IDLE.
- **WAIT_HDR**
  - `pkt_header_valid_strobe` latches rate and len, then go to EMIT with idx=0.
  - If the timeout counter reaches HDR_TIMEOUT-1 first, drop the record, increment `drop_count`, go to IDLE.
- **EMIT**
  - On each cycle with `fulln_to_pl`=1, register word[idx] onto `data_to_ps`, pulse `data_to_ps_valid` and increment idx.
  - After word 33, go to IDLE.
  - With `fulln_to_pl`=0 there is no strobe and idx holds.

Record layout (34 words):
- word0 = {16'h5A5A, 8'h00, pkt_rate, pkt_len, 16'd34}.
- word1 = tsf_r.
- words 2..33 = buffer entries 0..31, i.e. {csi[2k+1], csi[2k]}.

Drops and enable:
- A `csi_valid` rising edge (low previous cycle, high now) seen in WAIT_HDR or EMIT means a packet was missed. Increment `drop_count` once per edge. The incoming samples are ignored.
- `enable` falling outside IDLE does not abort; the current record completes.

## Timing
- Reset values:
  - `data_to_ps`=0, `data_to_ps_valid`=0, `busy`=0, `drop_count`=0.
  - State IDLE; cnt, idx and the timeout counter are 0.
- Outputs are registered.
- Header strobe in WAIT_HDR at cycle t: EMIT from t+1. The first `data_to_ps_valid` is at t+2 if `fulln_to_pl` was 1 at t+1.
- An unstalled record takes 34 consecutive valid cycles.
- `fulln_to_pl` sampled at cycle c controls the strobe at c+1. The FIFO guarantees ≥1 word of margin when it deasserts `fulln_to_pl`.
- `busy` rises the cycle after the first captured `csi_valid`. It falls the cycle after word 33 is strobed, or the cycle after a drop.
- Simultaneous events:
  - `csi_valid` and header strobe together in COLLECT: the header strobe wins, the record drops and the sample is discarded.
  - Header strobe on the same cycle the timeout expires: the header wins.
- `rst` mid-EMIT: `data_to_ps_valid` is 0 the next cycle and the partial record is not completed.

## Test plan
- Basic record: `enable`=1, 64 `csi_valid` with csi=k (k=0..63), TSF=64'h1000 at the first sample, then a header strobe with rate=8'h0B, len=16'd100, `fulln_to_pl`=1.
  - Expect 34 consecutive strobes.
  - word0=64'h5A5A_000B_0064_0022, word1=64'h1000, word2=64'h1_00000000, word33=64'h3F_0000003E.
- Backpressure: as the basic record, but `fulln_to_pl` toggles 1/0 every cycle during EMIT.
  - Expect words in order with no loss or duplication, 34 strobes total, and no strobe in the cycle after a sampled 0.
- Header timeout: 64 CSI samples, no header for HDR_TIMEOUT cycles.
  - Expect `drop_count`=1, `busy`=0 and no `data_to_ps_valid`.
- Incomplete CSI: 10 samples, then a header strobe.
  - Expect `drop_count`=1, return to IDLE; a following full packet emits correctly.
- Missed packet: a new `csi_valid` burst of 64 during EMIT.
  - Expect `drop_count` +1 exactly once and the current record unchanged.
- Mid-record reset: pulse `rst` at word 10 of EMIT.
  - Expect `data_to_ps_valid`=0 next cycle, `drop_count`=0, and the next packet records normally.
